// File: rtl/uart_pkg.sv
// Shared constants for the UART receiver: parity encodings, FSM state codes,
// legal parameter limits and the parity-check helper.
package uart_pkg;

  // Parity mode encodings
  localparam int unsigned ParityNone = 0;
  localparam int unsigned ParityEven = 1;
  localparam int unsigned ParityOdd  = 2;

  // Legal parameter limits
  localparam int unsigned DataBitsMin   = 5;
  localparam int unsigned DataBitsMax   = 9;
  localparam int unsigned StopBitsMin   = 1;
  localparam int unsigned StopBitsMax   = 2;
  localparam int unsigned ClksPerBitMin = 8;

  // FSM state codes; neighbouring states differ in one bit
  localparam int unsigned StateW = 3;
  localparam logic [StateW-1:0] StIdle   = 3'b000;
  localparam logic [StateW-1:0] StStart  = 3'b001;
  localparam logic [StateW-1:0] StData   = 3'b011;
  localparam logic [StateW-1:0] StParity = 3'b010;
  localparam logic [StateW-1:0] StStop   = 3'b110;

  // Returns 1 when the received parity bit disagrees with the data word.
  function automatic logic parity_error(input int unsigned mode, input logic data_xor,
                                        input logic par_bit);
    logic w_sum;
    w_sum = data_xor ^ par_bit;
    if (mode == ParityEven) begin
      return w_sum;
    end else if (mode == ParityOdd) begin
      return ~w_sum;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period timer: free-runs while not restarted and pulses tick on the last
// cycle of either a full or a half bit period, then wraps to zero.
module uart_baud_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic nrst,
  input  logic restart,
  input  logic half,
  output logic tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  logic [CntW-1:0] r_cnt;
  logic            w_tick;

  assign w_tick = (r_cnt == (half ? HalfLast : FullLast));
  assign tick   = w_tick;

  // Count cycles within a bit period; restart and tick both return to zero
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_cnt <= '0;
    end else if (restart || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronizes rx, frames start/data/parity/stop bits with a
// mid-bit sampling FSM, and holds the last word with flag and error status.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 1,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 rx,
  input  logic                 rx_flag_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_flag,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned BitCntW = $clog2(DATA_BITS + 1);
  localparam logic [BitCntW-1:0] LastData = BitCntW'(DATA_BITS - 1);
  localparam logic [BitCntW-1:0] LastStop = BitCntW'(STOP_BITS - 1);

  logic                 r_sync1, r_sync2;
  logic                 w_rxs;
  logic [StateW-1:0]    r_state, w_state_nxt;
  logic [BitCntW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_par_bit, w_par_bit_nxt;
  logic                 r_ferr, w_ferr_nxt;
  logic                 w_done, w_done_ferr, w_perr;
  logic                 w_tick;

  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_flag, r_parity_err, r_frame_err, r_overrun;

  assign w_rxs = r_sync2;

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Timer is held at zero in IDLE so START begins a clean half-bit count
  uart_baud_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_timer (
    .clk    (clk),
    .nrst   (nrst),
    .restart(r_state == StIdle),
    .half   (r_state == StStart),
    .tick   (w_tick)
  );

  // Next-state logic for the frame FSM and its datapath registers
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_par_bit_nxt = r_par_bit;
    w_ferr_nxt    = r_ferr;
    w_done        = 1'b0;
    w_done_ferr   = r_ferr | ~w_rxs;
    case (r_state)
      StIdle: begin
        if (!w_rxs) begin
          w_state_nxt   = StStart;
          w_bit_cnt_nxt = '0;
          w_ferr_nxt    = 1'b0;
        end
      end
      StStart: begin
        if (w_tick) begin
          // A high line at mid start bit is a glitch, not a frame
          w_state_nxt   = w_rxs ? StIdle : StData;
          w_bit_cnt_nxt = '0;
        end
      end
      StData: begin
        if (w_tick) begin
          w_shift_nxt = {w_rxs, r_shift[DATA_BITS-1:1]};
          if (r_bit_cnt == LastData) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = (PARITY_MODE != ParityNone) ? StParity : StStop;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      StParity: begin
        if (w_tick) begin
          w_par_bit_nxt = w_rxs;
          w_state_nxt   = StStop;
        end
      end
      StStop: begin
        if (w_tick) begin
          if (!w_rxs) begin
            w_ferr_nxt = 1'b1;
          end
          if (r_bit_cnt == LastStop) begin
            w_done        = 1'b1;
            w_state_nxt   = StIdle;
            w_bit_cnt_nxt = '0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_perr = parity_error(PARITY_MODE, ^r_shift, r_par_bit);

  // FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state   <= StIdle;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_par_bit <= w_par_bit_nxt;
      r_ferr    <= w_ferr_nxt;
    end
  end

  // Output holding registers; a completing frame takes priority over the clear
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_rx_data    <= '0;
      r_rx_flag    <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_done) begin
      r_rx_data    <= r_shift;
      r_rx_flag    <= 1'b1;
      r_parity_err <= w_perr;
      r_frame_err  <= w_done_ferr;
      r_overrun    <= r_rx_flag & ~rx_flag_clr;
    end else if (rx_flag_clr && r_rx_flag) begin
      r_rx_flag    <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_flag    = r_rx_flag;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: a table of 8N-even frames on one instance,
// hand sequences for false start, overrun, clear races and mid-frame reset,
// and a 7-bit odd-parity two-stop instance.
module tb_uart_rx_core;

  localparam int Cpb = 16;
  // Edge count from driving the start bit to the completing edge:
  // 2 sync flops + 1 IDLE cycle + half bit, then one full bit per later bit.
  localparam int DoneN0 = 3 + Cpb / 2 + Cpb * 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst;
  logic       rx0, clr0, rx1, clr1;
  logic [7:0] data0;
  logic       flag0, perr0, ferr0, ovr0, busy0;
  logic [6:0] data1;
  logic       flag1, perr1, ferr1, ovr1, busy1;

  uart_rx_core #(
    .DATA_BITS   (8),
    .PARITY_MODE (1),
    .STOP_BITS   (1),
    .CLKS_PER_BIT(Cpb)
  ) u_dut0 (
    .clk        (clk),
    .nrst       (nrst),
    .rx         (rx0),
    .rx_flag_clr(clr0),
    .rx_data    (data0),
    .rx_flag    (flag0),
    .parity_err (perr0),
    .frame_err  (ferr0),
    .overrun    (ovr0),
    .busy       (busy0)
  );

  uart_rx_core #(
    .DATA_BITS   (7),
    .PARITY_MODE (2),
    .STOP_BITS   (2),
    .CLKS_PER_BIT(Cpb)
  ) u_dut1 (
    .clk        (clk),
    .nrst       (nrst),
    .rx         (rx1),
    .rx_flag_clr(clr1),
    .rx_data    (data1),
    .rx_flag    (flag1),
    .parity_err (perr1),
    .frame_err  (ferr1),
    .overrun    (ovr1),
    .busy       (busy1)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    bit         par;
    bit         stopv;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame LSB first on line sel. clr_cyc pulses the clear for the
  // cycle ending at that edge index; stop_n aborts the frame early.
  task automatic send(input int sel, input logic [8:0] data, input int nbits, input bit haspar,
                      input bit par, input int nstop, input bit stopv, input int clr_cyc,
                      input bit chk_lat, input int stop_n);
    logic bits[16];
    int   nb;
    int   done_n;
    bits[0] = 1'b0;
    for (int i = 0; i < nbits; i++) bits[1+i] = data[i];
    nb = 1 + nbits;
    if (haspar) begin
      bits[nb] = par;
      nb++;
    end
    for (int i = 0; i < nstop; i++) bits[nb+i] = stopv;
    nb = nb + nstop;
    done_n = 3 + Cpb / 2 + Cpb * (nb - 1);
    for (int n = 0; n < nb * Cpb; n++) begin
      if (stop_n >= 0 && n == stop_n) break;
      if (sel == 0) begin
        rx0  = bits[n/Cpb];
        clr0 = (n == clr_cyc);
      end else begin
        rx1  = bits[n/Cpb];
        clr1 = (n == clr_cyc);
      end
      if (chk_lat && n == done_n - 1) begin
        check("lat_busy_before_stop", int'(busy0), 1);
        check("lat_flag_before_stop", int'(flag0), 0);
      end
      if (chk_lat && n == done_n + 1) begin
        check("lat_busy_after_stop", int'(busy0), 0);
        check("lat_flag_after_stop", int'(flag0), 1);
      end
      @(posedge clk);
      #1;
    end
    rx0  = 1'b1;
    rx1  = 1'b1;
    clr0 = 1'b0;
    clr1 = 1'b0;
  endtask

  task automatic clear0();
    clr0 = 1'b1;
    tick_n(1);
    clr0 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    //          data   par stop exp   perr ferr
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
    vecs[3] = '{8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
    vecs[4] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[5] = '{8'hFE, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

    nrst = 1'b1;
    rx0  = 1'b1;
    rx1  = 1'b1;
    clr0 = 1'b0;
    clr1 = 1'b0;
    tick_n(3);
    check("rst_data", int'(data0), 0);
    check("rst_flag", int'(flag0), 0);
    check("rst_perr", int'(perr0), 0);
    check("rst_ferr", int'(ferr0), 0);
    check("rst_ovr", int'(ovr0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_flag1", int'(flag1), 0);
    check("rst_busy1", int'(busy1), 0);
    nrst = 1'b0;
    tick_n(20);

    for (int i = 0; i < 7; i++) begin
      send(0, {1'b0, vecs[i].data}, 8, 1'b1, vecs[i].par, 1, vecs[i].stopv, -1, (i == 0), -1);
      tick_n(2);
      check($sformatf("v%0d_data", i), int'(data0), int'(vecs[i].exp_data));
      check($sformatf("v%0d_flag", i), int'(flag0), 1);
      check($sformatf("v%0d_perr", i), int'(perr0), int'(vecs[i].exp_perr));
      check($sformatf("v%0d_ferr", i), int'(ferr0), int'(vecs[i].exp_ferr));
      check($sformatf("v%0d_ovr", i), int'(ovr0), 0);
      clear0();
      check($sformatf("v%0d_clr_flag", i), int'(flag0), 0);
      check($sformatf("v%0d_clr_perr", i), int'(perr0), 0);
      check($sformatf("v%0d_clr_ferr", i), int'(ferr0), 0);
      check($sformatf("v%0d_clr_data", i), int'(data0), int'(vecs[i].exp_data));
      tick_n(3);
    end

    // False start: 4-cycle low glitch
    rx0 = 1'b0;
    tick_n(4);
    rx0 = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick_n(1);
      if (busy0) saw = 1'b1;
    end
    check("fs_busy_seen", int'(saw), 1);
    check("fs_busy_end", int'(busy0), 0);
    check("fs_flag", int'(flag0), 0);
    check("fs_ferr", int'(ferr0), 0);

    // Clear with no pending frame
    clear0();
    check("idle_clr_flag", int'(flag0), 0);
    check("idle_clr_ovr", int'(ovr0), 0);

    // Overrun: two frames without acknowledge
    send(0, 9'h011, 8, 1'b1, 1'b0, 1, 1'b1, -1, 1'b0, -1);
    tick_n(2);
    send(0, 9'h022, 8, 1'b1, 1'b0, 1, 1'b1, -1, 1'b0, -1);
    tick_n(2);
    check("ovr_data", int'(data0), 'h22);
    check("ovr_flag", int'(flag0), 1);
    check("ovr_set", int'(ovr0), 1);
    check("ovr_perr", int'(perr0), 0);
    clear0();
    check("ovr_cleared", int'(ovr0), 0);
    check("ovr_flag_cleared", int'(flag0), 0);

    // Clear coinciding with completion: completion wins, no overrun
    send(0, 9'h011, 8, 1'b1, 1'b0, 1, 1'b1, -1, 1'b0, -1);
    tick_n(2);
    send(0, 9'h022, 8, 1'b1, 1'b0, 1, 1'b1, DoneN0 - 1, 1'b0, -1);
    tick_n(2);
    check("race_flag", int'(flag0), 1);
    check("race_ovr", int'(ovr0), 0);
    check("race_data", int'(data0), 'h22);
    clear0();
    tick_n(2);

    // Reset during data bit 4, with a frame still pending beforehand
    send(0, 9'h0A5, 8, 1'b1, 1'b0, 1, 1'b1, -1, 1'b0, -1);
    tick_n(2);
    send(0, 9'h081, 8, 1'b1, 1'b0, 1, 1'b1, -1, 1'b0, Cpb * 5 + 5);
    nrst = 1'b1;
    tick_n(2);
    nrst = 1'b0;
    check("mrst_data", int'(data0), 0);
    check("mrst_flag", int'(flag0), 0);
    check("mrst_perr", int'(perr0), 0);
    check("mrst_ferr", int'(ferr0), 0);
    check("mrst_ovr", int'(ovr0), 0);
    check("mrst_busy", int'(busy0), 0);
    tick_n(Cpb * 12);
    check("mrst_no_flag", int'(flag0), 0);
    send(0, 9'h081, 8, 1'b1, 1'b0, 1, 1'b1, -1, 1'b0, -1);
    tick_n(2);
    check("mrst_next_data", int'(data0), 'h81);
    check("mrst_next_flag", int'(flag0), 1);
    check("mrst_next_perr", int'(perr0), 0);
    check("mrst_next_ferr", int'(ferr0), 0);
    clear0();

    // 7 data bits, odd parity, two stop bits
    send(1, 9'h07F, 7, 1'b1, 1'b0, 2, 1'b1, -1, 1'b0, -1);
    tick_n(2);
    check("odd_data", int'(data1), 'h7F);
    check("odd_flag", int'(flag1), 1);
    check("odd_perr", int'(perr1), 0);
    check("odd_ferr", int'(ferr1), 0);
    check("odd_ovr", int'(ovr1), 0);
    clr1 = 1'b1;
    tick_n(1);
    clr1 = 1'b0;
    check("odd_clr_flag", int'(flag1), 0);
    send(1, 9'h07F, 7, 1'b1, 1'b1, 2, 1'b1, -1, 1'b0, -1);
    tick_n(2);
    check("odd_bad_perr", int'(perr1), 1);
    check("odd_bad_data", int'(data1), 'h7F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
